// File: rtl/bank_row_tracker_array_pkg.sv
// Shared definitions for the DDR3 MCB open-row tracker: default field geometry,
// classification enum and the classification helper.
package mcb_pkg;

  localparam int MCB_AW         = 32;
  localparam int MCB_BA_W       = 3;
  localparam int MCB_RA_W       = 13;
  localparam int MCB_CA_W       = 10;
  localparam int MCB_BA_LSB     = 23;
  localparam int MCB_RA_LSB     = 10;
  localparam int MCB_CA_LSB     = 0;
  localparam int MCB_IDLE_W     = 8;
  localparam int MCB_IDLE_LIMIT = 64;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HIT   = 2'd1,
    MISS  = 2'd2
  } row_class_e;

  // A closed bank is always empty; an open bank hits only on a row match.
  function automatic row_class_e classify(input logic bank_open, input logic row_match);
    if (!bank_open)
      return EMPTY;
    return row_match ? HIT : MISS;
  endfunction

endpackage

// File: rtl/bank_row_tracker_array_bank_row_state.sv
// One bank's open-row state: open flag, open row address and idle counter.
module bank_row_state
  import mcb_pkg::*;
#(
  parameter int RA_W       = MCB_RA_W,
  parameter int IDLE_W     = MCB_IDLE_W,
  parameter int IDLE_LIMIT = MCB_IDLE_LIMIT
) (
  input  logic            ddr3_mcb_clk,
  input  logic            ddr3_mcb_rst_n,
  input  logic            act,
  input  logic            pre,
  input  logic            c_ref,
  input  logic            req_hit,
  input  logic [RA_W-1:0] act_ra,
  output logic            open,
  output logic [RA_W-1:0] row,
  output logic            idle_pre_req
);

  localparam logic [IDLE_W-1:0] LIMIT = IDLE_W'(IDLE_LIMIT);

  logic [IDLE_W-1:0] idle_cnt;

  // Open/row update: refresh and precharge both win over activate.
  always_ff @(posedge ddr3_mcb_clk or negedge ddr3_mcb_rst_n) begin
    if (!ddr3_mcb_rst_n) begin
      open <= 1'b0;
      row  <= '0;
    end else if (c_ref || pre) begin
      open <= 1'b0;
    end else if (act) begin
      open <= 1'b1;
      row  <= act_ra;
    end
  end

  // Idle counter: restarts on any bank activity or while closed, saturates at the limit.
  always_ff @(posedge ddr3_mcb_clk or negedge ddr3_mcb_rst_n) begin
    if (!ddr3_mcb_rst_n) begin
      idle_cnt <= '0;
    end else if (IDLE_LIMIT == 0 || c_ref || pre || act || req_hit || !open) begin
      idle_cnt <= '0;
    end else if (idle_cnt != LIMIT) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign idle_pre_req = (IDLE_LIMIT != 0) && open && (idle_cnt == LIMIT);

endmodule

// File: rtl/bank_row_tracker_array.sv
// Open-row tracker: decodes request addresses, classifies them against per-bank
// open-row state and returns the result through a one-deep valid/ready stage.
module bank_row_tracker_array
  import mcb_pkg::*;
#(
  parameter int AW         = MCB_AW,
  parameter int BA_W       = MCB_BA_W,
  parameter int RA_W       = MCB_RA_W,
  parameter int CA_W       = MCB_CA_W,
  parameter int BA_LSB     = MCB_BA_LSB,
  parameter int RA_LSB     = MCB_RA_LSB,
  parameter int CA_LSB     = MCB_CA_LSB,
  parameter int IDLE_W     = MCB_IDLE_W,
  parameter int IDLE_LIMIT = MCB_IDLE_LIMIT
) (
  input  logic                  ddr3_mcb_clk,
  input  logic                  ddr3_mcb_rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [AW-1:0]         req_addr,
  input  logic                  req_wr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [BA_W-1:0]       rsp_ba,
  output logic [RA_W-1:0]       rsp_ra,
  output logic [CA_W-1:0]       rsp_ca,
  output logic                  rsp_wr_n,
  output logic                  rsp_hit,
  output logic                  rsp_miss,
  output logic                  rsp_empty,
  input  logic                  act_valid,
  input  logic [BA_W-1:0]       act_ba,
  input  logic [RA_W-1:0]       act_ra,
  input  logic                  pre_valid,
  input  logic [BA_W-1:0]       pre_ba,
  input  logic                  pre_all,
  input  logic                  c_ref,
  output logic [(2**BA_W)-1:0]  idle_pre_req
);

  localparam int NB = 2**BA_W;

  if (BA_LSB + BA_W > AW || RA_LSB + RA_W > AW || CA_LSB + CA_W > AW) begin : g_bad_fit
    $error("bank_row_tracker_array: address field exceeds AW");
  end
  if (!(BA_LSB + BA_W <= RA_LSB || RA_LSB + RA_W <= BA_LSB) ||
      !(BA_LSB + BA_W <= CA_LSB || CA_LSB + CA_W <= BA_LSB) ||
      !(RA_LSB + RA_W <= CA_LSB || CA_LSB + CA_W <= RA_LSB)) begin : g_bad_overlap
    $error("bank_row_tracker_array: address fields overlap");
  end
  if (IDLE_LIMIT < 0 || IDLE_LIMIT >= 2**IDLE_W) begin : g_bad_idle
    $error("bank_row_tracker_array: IDLE_LIMIT does not fit IDLE_W");
  end

  logic [BA_W-1:0]          req_ba;
  logic [RA_W-1:0]          req_ra;
  logic [CA_W-1:0]          req_ca;
  logic                     req_accept;
  row_class_e               req_class;
  logic [NB-1:0]            bank_open;
  logic [NB-1:0]            bank_act;
  logic [NB-1:0]            bank_pre;
  logic [NB-1:0]            bank_req;
  logic [NB-1:0][RA_W-1:0]  bank_row;
  logic                     unused_addr;

  assign req_ba      = req_addr[BA_LSB +: BA_W];
  assign req_ra      = req_addr[RA_LSB +: RA_W];
  assign req_ca      = req_addr[CA_LSB +: CA_W];
  assign unused_addr = &{1'b0, req_addr};

  assign req_ready  = !rsp_valid || rsp_ready;
  assign req_accept = req_valid && req_ready;

  // Fan the scheduler notifications and accepted requests out to per-bank strobes.
  always_comb begin
    bank_act = '0;
    bank_pre = '0;
    bank_req = '0;
    for (int b = 0; b < NB; b++) begin
      bank_act[b] = act_valid && (act_ba == BA_W'(b));
      bank_pre[b] = pre_valid && (pre_all || pre_ba == BA_W'(b));
      bank_req[b] = req_accept && (req_ba == BA_W'(b));
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_bank
    bank_row_state #(
      .RA_W       (RA_W),
      .IDLE_W     (IDLE_W),
      .IDLE_LIMIT (IDLE_LIMIT)
    ) u_bank (
      .ddr3_mcb_clk   (ddr3_mcb_clk),
      .ddr3_mcb_rst_n (ddr3_mcb_rst_n),
      .act            (bank_act[g]),
      .pre            (bank_pre[g]),
      .c_ref          (c_ref),
      .req_hit        (bank_req[g]),
      .act_ra         (act_ra),
      .open           (bank_open[g]),
      .row            (bank_row[g]),
      .idle_pre_req   (idle_pre_req[g])
    );
  end

  // Classify against the registered bank state; same-cycle ACT/PRE/REF are not forwarded.
  assign req_class = classify(bank_open[req_ba], bank_row[req_ba] == req_ra);

  // Response stage: load on accept, hold under back-pressure, clear when drained.
  always_ff @(posedge ddr3_mcb_clk or negedge ddr3_mcb_rst_n) begin
    if (!ddr3_mcb_rst_n) begin
      rsp_valid <= 1'b0;
      rsp_ba    <= '0;
      rsp_ra    <= '0;
      rsp_ca    <= '0;
      rsp_wr_n  <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_miss  <= 1'b0;
      rsp_empty <= 1'b0;
    end else if (req_accept) begin
      rsp_valid <= 1'b1;
      rsp_ba    <= req_ba;
      rsp_ra    <= req_ra;
      rsp_ca    <= req_ca;
      rsp_wr_n  <= !req_wr;
      rsp_hit   <= (req_class == HIT);
      rsp_miss  <= (req_class == MISS);
      rsp_empty <= (req_class == EMPTY);
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_miss  <= 1'b0;
      rsp_empty <= 1'b0;
    end
  end

endmodule
